// File: rtl/ex_mem_pipe.sv
// Elastic EX/MEM pipeline stage: valid/ready handshake, synchronous flush,
// optional two-entry skid buffer so upstream ready comes straight from a flop.
module ex_mem_pipe #(
   parameter int DATA_W = 87,
   parameter int SKID   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        count
);

   logic [1:0]        count_p0;
   logic [1:0]        count_nxt;
   logic [DATA_W-1:0] main_p0;
   logic [DATA_W-1:0] skid_data;
   logic              accept;
   logic              emit;
   logic              load_main;
   logic              load_skid;
   logic              refill;

   assign accept = in_valid & in_ready;
   assign emit   = out_valid & out_ready;

   // Stage 0: occupancy state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) count_p0 <= 2'd0;
      else     count_p0 <= count_nxt;
   end

   always_comb begin
      count_nxt = count_p0;
      load_main = 1'b0;
      load_skid = 1'b0;
      refill    = 1'b0;
      if (flush) begin
         count_nxt = 2'd0;
      end else begin
         case (count_p0)
            2'd0: begin
               if (accept) begin
                  count_nxt = 2'd1;
                  load_main = 1'b1;
               end
            end
            2'd1: begin
               if (accept && emit) begin
                  load_main = 1'b1;
               end else if (accept) begin
                  // Without a skid register ready implies out_ready here, so this arm is SKID-only
                  if (SKID != 0) begin
                     count_nxt = 2'd2;
                     load_skid = 1'b1;
                  end else begin
                     load_main = 1'b1;
                  end
               end else if (emit) begin
                  count_nxt = 2'd0;
               end
            end
            2'd2: begin
               if (emit) begin
                  count_nxt = 2'd1;
                  refill    = 1'b1;
               end
            end
            default: count_nxt = 2'd0;
         endcase
      end
   end

   always_comb begin
      out_valid = (count_p0 != 2'd0);
      out_data  = main_p0;
      count     = count_p0;
   end

   // Stage 0: head register feeding the memory stage
   always_ff @(posedge clk or posedge rst) begin
      if (rst)            main_p0 <= '0;
      else if (load_main) main_p0 <= in_data;
      else if (refill)    main_p0 <= skid_data;
   end

   generate
      if (SKID != 0) begin : g_skid
         logic [DATA_W-1:0] skid_p1;
         logic              rdy_p0;

         // Stage 1: overflow entry and registered upstream ready
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               skid_p1 <= '0;
               rdy_p0  <= 1'b1;
            end else begin
               rdy_p0 <= (count_nxt != 2'd2);
               if (load_skid) skid_p1 <= in_data;
            end
         end

         assign skid_data = skid_p1;
         assign in_ready  = rdy_p0;
      end else begin : g_noskid
         assign skid_data = '0;
         assign in_ready  = ~out_valid | out_ready;
      end
   endgenerate

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Bench for ex_mem_pipe: SKID=1 and SKID=0 instances on shared stimulus,
// vector table, directed corner sequences and a queue-based random model.
module tb_ex_mem_pipe;

   localparam int W = 87;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          in_valid;
   logic          out_ready;
   logic [W-1:0]  in_data;

   logic          in_ready1, out_valid1, in_ready0, out_valid0;
   logic [W-1:0]  out_data1, out_data0;
   logic [1:0]    count1, count0;

   int n_chk  = 0;
   int n_pass = 0;

   logic [W-1:0] q1[$];
   logic [W-1:0] q0[$];

   always #5 clk = ~clk;

   ex_mem_pipe #(.DATA_W(W), .SKID(1)) dut1 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
      .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
      .count(count1)
   );

   ex_mem_pipe #(.DATA_W(W), .SKID(0)) dut0 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
      .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
      .count(count0)
   );

   typedef struct {
      logic         fl;
      logic         iv;
      logic         ordy;
      logic [W-1:0] d;
      logic [1:0]   ecnt;
      logic         eov;
      logic         eir;
      logic [W-1:0] ed;
      logic         cd;
   } vec_t;

   vec_t tbl[13];

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s got %h want %h", nm, act, exp);
   endtask

   function automatic logic [W-1:0] rnd_data();
      logic [95:0] t;
      t = {$urandom, $urandom, $urandom};
      return t[W-1:0];
   endfunction

   // FIFO-level reference: capacity 2 with ready = not full, or capacity 1 with pass-through ready
   task automatic model_edge();
      bit acc1, emt1, acc0, emt0;
      acc1 = in_valid && (q1.size() < 2);
      emt1 = (q1.size() > 0) && out_ready;
      acc0 = in_valid && ((q0.size() == 0) || out_ready);
      emt0 = (q0.size() > 0) && out_ready;
      if (rst || flush) begin
         q1.delete();
         q0.delete();
      end else begin
         if (emt1) void'(q1.pop_front());
         if (acc1) q1.push_back(in_data);
         if (emt0) void'(q0.pop_front());
         if (acc0) q0.push_back(in_data);
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic cmp_model();
      chk("cnt1", W'(count1), W'(q1.size()));
      chk("ov1", W'(out_valid1), W'(q1.size() != 0));
      chk("ir1", W'(in_ready1), W'(q1.size() < 2));
      if (q1.size() > 0) chk("dat1", out_data1, q1[0]);
      chk("cnt0", W'(count0), W'(q0.size()));
      chk("ov0", W'(out_valid0), W'(q0.size() != 0));
      if (q0.size() > 0) chk("dat0", out_data0, q0[0]);
   endtask

   task automatic idle_flush();
      flush = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      step();
      flush = 1'b0;
   endtask

   initial begin
      int rds[3];
      logic [W-1:0] v;

      rds = '{5, 0, 31};
      //          fl iv or d        cnt  ov ir  ed       cd
      tbl[0]  = '{0, 1, 0, W'('h1), 2'd1, 1, 1, W'('h1), 1};
      tbl[1]  = '{0, 1, 0, W'('h2), 2'd2, 1, 0, W'('h1), 1};
      tbl[2]  = '{0, 1, 0, W'('h3), 2'd2, 1, 0, W'('h1), 1};
      tbl[3]  = '{0, 1, 1, W'('h3), 2'd1, 1, 1, W'('h2), 1};
      tbl[4]  = '{0, 1, 1, W'('h3), 2'd1, 1, 1, W'('h3), 1};
      tbl[5]  = '{0, 0, 1, W'('h0), 2'd0, 0, 1, W'('h0), 0};
      tbl[6]  = '{0, 1, 0, W'('hA), 2'd1, 1, 1, W'('hA), 1};
      tbl[7]  = '{0, 1, 0, W'('hB), 2'd2, 1, 0, W'('hA), 1};
      tbl[8]  = '{1, 1, 1, W'('hC), 2'd0, 0, 1, W'('h0), 0};
      tbl[9]  = '{0, 0, 1, W'('h0), 2'd0, 0, 1, W'('h0), 0};
      tbl[10] = '{0, 1, 1, W'('hD), 2'd1, 1, 1, W'('hD), 1};
      tbl[11] = '{0, 0, 0, W'('h0), 2'd1, 1, 1, W'('hD), 1};
      tbl[12] = '{0, 0, 1, W'('h0), 2'd0, 0, 1, W'('h0), 0};

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      #1;
      chk("rst_cnt", W'(count1), W'(0));
      chk("rst_ov", W'(out_valid1), W'(0));
      chk("rst_ir", W'(in_ready1), W'(1));
      chk("rst_dat", out_data1, W'(0));
      step();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Vector table: backpressure A/B/C, flush while full with input offered
      for (int i = 0; i < 13; i++) begin
         flush = tbl[i].fl; in_valid = tbl[i].iv; out_ready = tbl[i].ordy; in_data = tbl[i].d;
         step();
         chk($sformatf("tbl%0d_cnt", i), W'(count1), W'(tbl[i].ecnt));
         chk($sformatf("tbl%0d_ov", i), W'(out_valid1), W'(tbl[i].eov));
         chk($sformatf("tbl%0d_ir", i), W'(in_ready1), W'(tbl[i].eir));
         if (tbl[i].cd) chk($sformatf("tbl%0d_dat", i), out_data1, tbl[i].ed);
      end
      flush = 1'b0;

      // Streaming at full rate
      idle_flush();
      out_ready = 1'b1;
      for (int k = 16; k < 32; k++) begin
         in_valid = 1'b1; in_data = W'(k);
         step();
         chk("strm_dat", out_data1, W'(k));
         chk("strm_cnt", W'(count1), W'(1));
      end
      in_valid = 1'b0;
      step();
      chk("strm_drain", W'(count1), W'(0));

      // Destination register field survives every transfer
      for (int k = 0; k < 3; k++) begin
         v = rnd_data();
         v[36:32] = rds[k][4:0];
         in_valid = 1'b1; out_ready = 1'b1; in_data = v;
         step();
         chk("rd_field", W'(out_data1[36:32]), W'(rds[k]));
      end
      in_valid = 1'b0;
      step();

      // Asynchronous reset with two entries held, then rst together with flush
      idle_flush();
      in_valid = 1'b1; in_data = W'('hAA);
      step();
      in_data = W'('hBB);
      step();
      chk("pre_rst_cnt", W'(count1), W'(2));
      @(negedge clk);
      rst = 1'b1;
      #1;
      q1.delete(); q0.delete();
      chk("arst_cnt", W'(count1), W'(0));
      chk("arst_ov", W'(out_valid1), W'(0));
      chk("arst_ir", W'(in_ready1), W'(1));
      chk("arst_dat", out_data1, W'(0));
      flush = 1'b1; out_ready = 1'b1;
      step();
      chk("rstfl_cnt", W'(count1), W'(0));
      chk("rstfl_ov0", W'(out_valid0), W'(0));
      flush = 1'b0;
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b1; out_ready = 1'b0; in_data = W'('h1);
      step();
      chk("rel_dat", out_data1, W'('h1));
      chk("rel_ov", W'(out_valid1), W'(1));

      // SKID=0: combinational ready and same-edge accept/emit
      idle_flush();
      in_valid = 1'b1; in_data = W'('h55);
      step();
      chk("s0_cnt", W'(count0), W'(1));
      in_data = W'('h66);
      #1;
      chk("s0_ir_lo", W'(in_ready0), W'(0));
      out_ready = 1'b1;
      #1;
      chk("s0_ir_hi", W'(in_ready0), W'(1));
      step();
      chk("s0_cnt2", W'(count0), W'(1));
      chk("s0_dat", out_data0, W'('h66));

      // Randomized traffic against the FIFO model
      idle_flush();
      cmp_model();
      for (int n = 0; n < 500; n++) begin
         flush     = ($urandom_range(15) == 0);
         in_valid  = ($urandom_range(3) != 0);
         out_ready = ($urandom_range(2) != 0);
         in_data   = rnd_data();
         #1;
         chk("rnd_ir0", W'(in_ready0), W'((q0.size() == 0) || out_ready));
         step();
         cmp_model();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/ex_mem_pipe.md
# ex_mem_pipe

Parametrised, elastic EX/MEM pipeline stage for the RV32 core. Moves one execute-stage result bundle per cycle to the memory stage using a valid/ready handshake, so the memory stage can stall without a global enable. A synchronous flush kills in-flight entries. An optional two-entry skid buffer gives a fully registered upstream ready. Every bundle field, including the destination register index, is captured on each transfer.

## Interface

Parameters:
- DATA_W, default 87: bundle width. Default packs alu_out[31:0], B_result, opcode[6:0], funct3[2:0], funct7[6:0], rd[4:0], rs2_data[31:0], MSB first in that order.
- SKID, default 1:
  - 1: two-entry skid buffer with registered in_ready.
  - 0: single register with combinational in_ready.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  upstream has a bundle
- in_ready  out  1  stage can accept
- in_data  in  DATA_W  upstream bundle
- out_valid  out  1  out_data holds a valid bundle
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  head bundle
- count  out  2  occupancy, 0..2 (0..1 when SKID=0)

## Operation

- Transfer rules:
  - Accept: in_valid & in_ready at a rising edge.
  - Emit: out_valid & out_ready at a rising edge.
- Order is strictly FIFO. There is no bypass: a bundle never reaches out_data in the cycle it is accepted.
- Storage: main register (drives out_data) and, when SKID=1, a skid register.
- State = count. Transitions with SKID=1:
  - EMPTY (0):
    - accept → ONE, main ← in_data.
  - ONE (1):
    - accept & emit → ONE, main ← in_data.
    - accept & no emit → FULL, skid ← in_data.
    - emit & no accept → EMPTY.
    - neither → ONE, hold.
  - FULL (2):
    - in_ready is 0, so no accept is possible.
    - emit → ONE, main ← skid.
    - otherwise hold.
- Outputs and ready, SKID=1:
  - out_valid = (count != 0).
  - in_ready = (count != 2), taken from a flop with no combinational path from out_ready.
- SKID=0 behaviour:
  - in_ready = ~out_valid | out_ready (combinational).
  - Accept loads main; count is 1 after any accept, and 0 after emit without accept.
- Flush:
  - Highest priority over both accept and emit.
  - Next state: count 0, out_valid 0, in_ready 1.
  - A bundle presented with in_valid in the flush cycle is discarded, even though in_ready was high.
  - Data registers keep their contents. out_data is don't-care while out_valid=0.
- Data registers load only on the accept/refill events listed above. They never change on an idle cycle.

## Timing

- Reset (asynchronous, immediate): count 0, out_valid 0, in_ready 1, out_data 0, skid register 0.
- Reset release: the first accept can occur on the first rising edge after rst deasserts.
- Latency: a bundle accepted at edge N is presented at out_data/out_valid after edge N when the stage was empty.
- Throughput: 1 bundle per cycle sustained when out_ready is held at 1.
- Backpressure, SKID=1:
  - out_ready low for k cycles absorbs at most one extra bundle.
  - in_ready falls the cycle after count reaches 2.
  - in_ready rises the cycle after an emit from FULL.
- Simultaneous accept and emit in ONE keeps count at 1, with no bubble and no duplication.
- Reset asserted mid-operation drops all entries immediately. No emit occurs while rst=1.
- flush and rst together: rst wins, with the same resulting state.

## Test plan

- **Reset:** assert rst with held entries → count 0, out_valid 0, in_ready 1, out_data 0 immediately. Release, then in_data=0x1 with in_valid → out_data=0x1 and out_valid=1 one edge later.
- **Streaming:** out_ready=1, send 0x10..0x1F back-to-back → same 16 values emerge in order, one per cycle, with 1-cycle latency and count constant at 1.
- **Backpressure (SKID=1):** out_ready=0, offer A, B, C on consecutive cycles → A and B accepted, count=2, in_ready=0, C held upstream. Raise out_ready → A, B, C emitted in order, no loss or duplicate.
- **rd capture:** sequence with rd field 5, 0, 31 → the rd bits of out_data equal 5, 0, 31 on the respective emits.
- **Flush while FULL with in_valid=1:** → next cycle count 0, out_valid 0, in_ready 1. No flushed bundle and no flush-cycle input ever appears at the output.
- **SKID=0 build:** out_ready=0 with one entry held → in_ready=0. Raise out_ready with in_valid=1 → same-edge accept and emit, count stays 1.
